// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-pointer engine and its
// pointer assembler.
package i2c_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    // Number of pointer bytes needed to carry an addr_w-bit pointer.
    function automatic int ptr_bytes(input int addr_w);
        return (addr_w + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/i2c_register_pointer_if.sv
// Byte-level link between the I2C bit engine (master side) and the
// register-pointer engine (slave side), including the memory-facing outputs.
interface i2c_register_pointer_if
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 7
);

    logic              dev_sel;
    logic              dev_rw;
    logic              stop_det;
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              tx_done;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_bit;
    logic              mem_write_bit;
    logic              wr_en;
    logic [BYTE_W-1:0] wr_data;
    logic              range_err;

    modport master (
        output dev_sel, dev_rw, stop_det, rx_valid, rx_byte, tx_done,
        input  mem_address, mem_read_bit, mem_write_bit, wr_en, wr_data, range_err
    );

    modport slave (
        input  dev_sel, dev_rw, stop_det, rx_valid, rx_byte, tx_done,
        output mem_address, mem_read_bit, mem_write_bit, wr_en, wr_data, range_err
    );

endinterface

// File: rtl/i2c_ptr_assembler.sv
// Collects the MSB-first pointer bytes of a write transaction and presents the
// assembled value, masked to ADDR_W bits, together with the final byte.
module i2c_ptr_assembler
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 7
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              done,
    output logic [15:0]       value
);

    localparam int NB = ptr_bytes(ADDR_W);

    logic [BYTE_W-1:0] stage_reg, stage_next;
    logic              idx_reg, idx_next;
    logic              last_byte;
    logic [15:0]       assembled;

    assign last_byte = (NB == 1) || idx_reg;
    assign done      = rx_valid && !clr && last_byte;

    // The incoming byte completes the value combinationally so the pointer can
    // be loaded on the same edge that accepts the final byte.
    assign assembled = (NB == 1) ? {8'h00, rx_byte} : {stage_reg, rx_byte};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mask
            if (gi < ADDR_W) begin : g_keep
                assign value[gi] = assembled[gi];
            end else begin : g_drop
                assign value[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        stage_next = stage_reg;
        idx_next   = idx_reg;
        if (clr) begin
            stage_next = '0;
            idx_next   = 1'b0;
        end else if (rx_valid) begin
            stage_next = rx_byte;
            idx_next   = !last_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= '0;
            idx_reg   <= 1'b0;
        end else begin
            stage_reg <= stage_next;
            idx_reg   <= idx_next;
        end
    end

endmodule

// File: rtl/i2c_register_pointer.sv
// Register-pointer engine: tracks transaction direction, loads the pointer,
// issues write strobes and auto-increments with wrap or saturate.
module i2c_register_pointer
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int WRAP   = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    i2c_register_pointer_if.slave bus
);

    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
    localparam logic [31:0] DEPTH_M1 = 32'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rd_bit_reg, rd_bit_next;
    logic              wr_bit_reg, wr_bit_next;
    logic              wr_en_reg, wr_en_next;
    logic [BYTE_W-1:0] wr_data_reg, wr_data_next;
    logic              err_reg, err_next;

    logic              asm_clr;
    logic              asm_rx;
    logic              ptr_done;
    logic [15:0]       ptr_value;
    logic              rd_step;
    logic              adv;
    logic              at_last;
    logic              sat;
    logic              err_now;

    assign asm_clr = bus.dev_sel || bus.stop_det;
    assign asm_rx  = bus.rx_valid && (state_reg == PTR);

    i2c_ptr_assembler #(
        .ADDR_W (ADDR_W)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr),
        .rx_valid (asm_rx),
        .rx_byte  (bus.rx_byte),
        .done     (ptr_done),
        .value    (ptr_value)
    );

    // A write advances on the edge closing its strobe cycle; a read advances
    // on the edge that accepts tx_done.
    assign rd_step = (state_reg == RDATA) && bus.tx_done && !err_reg
                     && !bus.dev_sel && !bus.stop_det;
    assign adv     = wr_en_reg || rd_step;
    assign at_last = 32'(addr_reg) >= DEPTH_M1;
    assign sat     = adv && at_last && (WRAP == 0);
    // A byte arriving in the very cycle the pointer saturates must be dropped.
    assign err_now = err_reg || sat;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        rd_bit_next  = rd_bit_reg;
        wr_bit_next  = wr_bit_reg;
        wr_en_next   = 1'b0;
        wr_data_next = wr_data_reg;
        err_next     = err_reg;

        if (adv) begin
            if (!at_last) begin
                addr_next = addr_reg + 1'b1;
            end else if (WRAP != 0) begin
                addr_next = '0;
            end else begin
                err_next = 1'b1;
            end
        end

        if (bus.dev_sel) begin
            state_next  = bus.dev_rw ? RDATA : PTR;
            rd_bit_next = bus.dev_rw;
            wr_bit_next = !bus.dev_rw;
            err_next    = 1'b0;
        end else if (bus.stop_det) begin
            state_next  = IDLE;
            rd_bit_next = 1'b0;
            wr_bit_next = 1'b0;
        end else begin
            case (state_reg)
                PTR: begin
                    if (ptr_done) begin
                        if ({16'h0000, ptr_value} < DEPTH_W) begin
                            addr_next = ptr_value[ADDR_W-1:0];
                        end else begin
                            err_next = 1'b1;
                        end
                        state_next = WDATA;
                    end
                end
                WDATA: begin
                    if (bus.rx_valid && !err_now) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = bus.rx_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            rd_bit_reg  <= 1'b0;
            wr_bit_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            rd_bit_reg  <= rd_bit_next;
            wr_bit_reg  <= wr_bit_next;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= wr_data_next;
            err_reg     <= err_next;
        end
    end

    assign bus.mem_address   = addr_reg;
    assign bus.mem_read_bit  = rd_bit_reg;
    assign bus.mem_write_bit = wr_bit_reg;
    assign bus.wr_en         = wr_en_reg;
    assign bus.wr_data       = wr_data_reg;
    assign bus.range_err     = err_reg;

endmodule

// File: tb/tb_i2c_register_pointer.sv
// Scoreboard bench: three engine instances (wrapping, saturating, two-byte
// pointer) driven one at a time; expected writes are queued as data is sent.
module tb_i2c_register_pointer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int         sel = 0;
    logic       dev_sel = 1'b0, dev_rw = 1'b0, stop_det = 1'b0;
    logic       rx_valid = 1'b0, tx_done = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t exp_q[$];

    i2c_register_pointer_if #(.ADDR_W(7))  bus0 ();
    i2c_register_pointer_if #(.ADDR_W(7))  bus1 ();
    i2c_register_pointer_if #(.ADDR_W(10)) bus2 ();

    i2c_register_pointer #(.ADDR_W(7),  .DEPTH(128),  .WRAP(1)) u_wrap (.clk(clk), .rst(rst), .bus(bus0));
    i2c_register_pointer #(.ADDR_W(7),  .DEPTH(128),  .WRAP(0)) u_sat  (.clk(clk), .rst(rst), .bus(bus1));
    i2c_register_pointer #(.ADDR_W(10), .DEPTH(1000), .WRAP(1)) u_two  (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.dev_sel  = dev_sel  && (sel == 0);
    assign bus0.stop_det = stop_det && (sel == 0);
    assign bus0.rx_valid = rx_valid && (sel == 0);
    assign bus0.tx_done  = tx_done  && (sel == 0);
    assign bus0.dev_rw   = dev_rw;
    assign bus0.rx_byte  = rx_byte;
    assign bus1.dev_sel  = dev_sel  && (sel == 1);
    assign bus1.stop_det = stop_det && (sel == 1);
    assign bus1.rx_valid = rx_valid && (sel == 1);
    assign bus1.tx_done  = tx_done  && (sel == 1);
    assign bus1.dev_rw   = dev_rw;
    assign bus1.rx_byte  = rx_byte;
    assign bus2.dev_sel  = dev_sel  && (sel == 2);
    assign bus2.stop_det = stop_det && (sel == 2);
    assign bus2.rx_valid = rx_valid && (sel == 2);
    assign bus2.tx_done  = tx_done  && (sel == 2);
    assign bus2.dev_rw   = dev_rw;
    assign bus2.rx_byte  = rx_byte;

    logic [15:0] addr_o [3];
    logic [7:0]  wdat_o [3];
    logic        wen_o  [3];
    logic        rd_o   [3];
    logic        wr_o   [3];
    logic        err_o  [3];

    assign addr_o[0] = 16'(bus0.mem_address);
    assign addr_o[1] = 16'(bus1.mem_address);
    assign addr_o[2] = 16'(bus2.mem_address);
    assign wdat_o[0] = bus0.wr_data;
    assign wdat_o[1] = bus1.wr_data;
    assign wdat_o[2] = bus2.wr_data;
    assign wen_o[0]  = bus0.wr_en;
    assign wen_o[1]  = bus1.wr_en;
    assign wen_o[2]  = bus2.wr_en;
    assign rd_o[0]   = bus0.mem_read_bit;
    assign rd_o[1]   = bus1.mem_read_bit;
    assign rd_o[2]   = bus2.mem_read_bit;
    assign wr_o[0]   = bus0.mem_write_bit;
    assign wr_o[1]   = bus1.mem_write_bit;
    assign wr_o[2]   = bus2.mem_write_bit;
    assign err_o[0]  = bus0.range_err;
    assign err_o[1]  = bus1.range_err;
    assign err_o[2]  = bus2.range_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write-strobe monitor: every wr_en cycle must match the head of the queue.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wen_o[k]) begin
                $display("wr dut=%0d addr=0x%0h data=0x%0h", k, addr_o[k], wdat_o[k]);
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(wen_o[k]), 32'd0);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_dut",  32'(k),         32'(w.dut));
                    chk("wr_addr", 32'(addr_o[k]), 32'(w.addr));
                    chk("wr_data", 32'(wdat_o[k]), 32'(w.data));
                end
            end
        end
    end

    // Stimulus tasks start and end on a falling edge so consecutive calls
    // produce back-to-back pulses.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_dev(input int k, input logic rw);
        sel = k; dev_sel = 1'b1; dev_rw = rw;
        @(negedge clk);
        dev_sel = 1'b0; dev_rw = 1'b0;
    endtask

    task automatic do_stop();
        stop_det = 1'b1;
        @(negedge clk);
        stop_det = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] b, input logic [15:0] a);
        exp_q.push_back('{sel, a, b});
        do_rx(b);
    endtask

    task automatic do_tx();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        cyc(3);
        for (int k = 0; k < 3; k++) begin
            chk("rst_addr", 32'(addr_o[k]), 32'd0);
            chk("rst_rd",   32'(rd_o[k]),   32'd0);
            chk("rst_wr",   32'(wr_o[k]),   32'd0);
            chk("rst_err",  32'(err_o[k]),  32'd0);
            chk("rst_wen",  32'(wen_o[k]),  32'd0);
            chk("rst_wdat", 32'(wdat_o[k]), 32'd0);
        end
        rst = 1'b0;
        cyc(1);

        // Defaults: pointer 0x10, back-to-back data bytes.
        do_dev(0, 1'b0);
        chk("def_wrbit", 32'(wr_o[0]), 32'd1);
        chk("def_rdbit", 32'(rd_o[0]), 32'd0);
        do_rx(8'h10);
        chk("def_ptr", 32'(addr_o[0]), 32'h10);
        do_wr(8'hA5, 16'h10);
        do_wr(8'h3C, 16'h11);
        cyc(2);
        chk("def_after", 32'(addr_o[0]), 32'h12);
        do_stop();
        chk("def_stop_wr", 32'(wr_o[0]), 32'd0);
        chk("def_stop_addr", 32'(addr_o[0]), 32'h12);
        do_rx(8'h44);
        cyc(1);
        chk("idle_rx_addr", 32'(addr_o[0]), 32'h12);

        // Bit 7 of a 7-bit pointer byte is ignored.
        do_dev(0, 1'b0);
        do_rx(8'h90);
        chk("ptr_mask", 32'(addr_o[0]), 32'h10);

        // Wrap at DEPTH-1.
        do_dev(0, 1'b0);
        do_rx(8'h7F);
        do_wr(8'h11, 16'h7F);
        cyc(1);
        do_wr(8'h22, 16'h00);
        cyc(1);
        chk("wrap_addr", 32'(addr_o[0]), 32'h01);
        chk("wrap_err",  32'(err_o[0]),  32'd0);

        // Combined write-pointer then repeated-START read.
        do_dev(0, 1'b0);
        do_rx(8'h20);
        chk("comb_ptr", 32'(addr_o[0]), 32'h20);
        do_dev(0, 1'b1);
        chk("comb_rd", 32'(rd_o[0]), 32'd1);
        chk("comb_wr", 32'(wr_o[0]), 32'd0);
        chk("comb_addr0", 32'(addr_o[0]), 32'h20);
        do_tx();
        chk("comb_addr1", 32'(addr_o[0]), 32'h21);
        do_tx();
        chk("comb_addr2", 32'(addr_o[0]), 32'h22);
        do_rx(8'h55);
        chk("comb_rx_ign", 32'(addr_o[0]), 32'h22);
        do_tx();
        chk("comb_addr3", 32'(addr_o[0]), 32'h23);
        do_stop();
        chk("comb_stop_rd", 32'(rd_o[0]), 32'd0);

        // dev_sel beats stop_det in the same cycle.
        sel = 0; dev_sel = 1'b1; stop_det = 1'b1; dev_rw = 1'b0;
        @(negedge clk);
        dev_sel = 1'b0; stop_det = 1'b0;
        chk("sel_over_stop", 32'(wr_o[0]), 32'd1);

        // Reset in the cycle a data byte arrives: no strobe, all cleared.
        do_rx(8'h40);
        rst = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("rst_mid_wen",  32'(wen_o[0]),  32'd0);
        chk("rst_mid_addr", 32'(addr_o[0]), 32'd0);
        chk("rst_mid_wr",   32'(wr_o[0]),   32'd0);
        chk("rst_mid_wdat", 32'(wdat_o[0]), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Saturating instance: back-to-back bytes at DEPTH-1.
        do_dev(1, 1'b0);
        do_rx(8'h7F);
        do_wr(8'h11, 16'h7F);
        do_rx(8'h22);
        cyc(2);
        chk("sat_err",  32'(err_o[1]),  32'd1);
        chk("sat_addr", 32'(addr_o[1]), 32'h7F);
        do_dev(1, 1'b1);
        chk("sat_sel_clr", 32'(err_o[1]), 32'd0);
        do_tx();
        chk("sat_rd_err",  32'(err_o[1]),  32'd1);
        chk("sat_rd_addr", 32'(addr_o[1]), 32'h7F);
        do_stop();

        // Two-byte pointer instance.
        do_dev(2, 1'b0);
        do_rx(8'h03);
        chk("two_partial", 32'(addr_o[2]), 32'd0);
        do_rx(8'hE7);
        chk("two_999", 32'(addr_o[2]), 32'd999);
        chk("two_err0", 32'(err_o[2]), 32'd0);
        do_stop();
        do_dev(2, 1'b0);
        do_rx(8'h03);
        do_rx(8'hE8);
        chk("two_oor_err",  32'(err_o[2]),  32'd1);
        chk("two_oor_addr", 32'(addr_o[2]), 32'd999);
        do_rx(8'h77);
        cyc(2);
        chk("two_drop_addr", 32'(addr_o[2]), 32'd999);
        do_stop();
        do_dev(2, 1'b0);
        chk("two_sel_clr", 32'(err_o[2]), 32'd0);
        do_rx(8'h01);
        do_stop();
        chk("abort_addr", 32'(addr_o[2]), 32'd999);
        do_dev(2, 1'b0);
        do_rx(8'h00);
        do_rx(8'h05);
        chk("abort_fresh", 32'(addr_o[2]), 32'd5);
        do_wr(8'h66, 16'd5);
        cyc(2);
        chk("two_inc", 32'(addr_o[2]), 32'd6);
        do_stop();

        cyc(3);
        chk("q_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
